// File: rtl/main_memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// main_memory_responder_pkg
// Shared cache definitions: default geometry (address width, data width,
// words per line) and the responder FSM state encoding. cache_controller
// imports the same package, so both sides agree on these values.
// ---------------------------------------------------------------------------
package main_memory_responder_pkg;

   localparam int MM_ADDR_W     = 8;
   localparam int MM_DATA_W     = 8;
   localparam int MM_LINE_WORDS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2,
      ST_WRITE = 2'd3
   } mem_state_e;

endpackage

// File: rtl/main_memory_responder_mem_array.sv
// ---------------------------------------------------------------------------
// main_mem_array
// Backing store for the main memory responder: 2^ADDR_W words of DATA_W
// bits, one synchronous write port and one asynchronous read port.
// On reset every word is loaded with its own address.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (re-initialises contents)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : combinational read data
// ---------------------------------------------------------------------------
module main_mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_W'(i);
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/main_memory_responder.sv
// ---------------------------------------------------------------------------
// main_memory_responder
// Main-memory model answering the cache controller. A request is latched,
// waits LATENCY cycles, then either streams a whole cache line (one beat
// per cycle) or commits a single-word write and pulses mem_wack.
//
// Ports
//   CC_clk     : clock, rising edge
//   rst        : asynchronous active-high reset
//   mem_req    : request strobe (accepted only when the FSM can take it)
//   mem_we     : 1 = single-word write, 0 = line-fill read
//   mem_addr   : request byte address
//   mem_wdata  : write data
//   mem_busy   : high while an operation is in flight
//   mem_rvalid : qualifies mem_rdata / mem_beat
//   mem_rdata  : line-fill read data (holds when mem_rvalid is low)
//   mem_beat   : beat index within the line
//   mem_wack   : one-cycle pulse once a write has committed
// ---------------------------------------------------------------------------
module main_memory_responder
   import main_memory_responder_pkg::*;
#(
   parameter int ADDR_W     = MM_ADDR_W,
   parameter int DATA_W     = MM_DATA_W,
   parameter int LINE_WORDS = MM_LINE_WORDS,
   parameter int LATENCY    = 3,
   localparam int BEAT_W    = $clog2(LINE_WORDS)
) (
   input  logic              CC_clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_busy,
   output logic              mem_rvalid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic [BEAT_W-1:0] mem_beat,
   output logic              mem_wack
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam int IDX_W = BEAT_W + 1;

   mem_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [IDX_W-1:0]  idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;

   logic              burst_done;
   logic              accept;
   logic              mem_wr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   // idx_q == LINE_WORDS means every beat has been issued; this is the
   // completion cycle of a burst.
   assign burst_done = (state_q == ST_BURST) && (idx_q == IDX_W'(LINE_WORDS));

   // A new request is taken in IDLE and also on the edge that completes the
   // current operation, so a requester holding mem_req gets back-to-back
   // service without an idle bubble.
   assign accept = mem_req &&
                   ((state_q == ST_IDLE) || (state_q == ST_WRITE) || burst_done);

   assign cnt_d  = cnt_q - CNT_W'(1);
   assign mem_wr = (state_q == ST_WRITE);

   // Line base has its low bits cleared, so substituting the beat index
   // there stays inside the line and never carries into the next one.
   assign rd_addr = {addr_q[ADDR_W-1:BEAT_W], idx_q[BEAT_W-1:0]};

   main_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk_i   (CC_clk),
      .rst_i   (rst),
      .we_i    (mem_wr),
      .waddr_i (addr_q),
      .wdata_i (wdata_q),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   // Request payload: data only, no reset needed.
   always_ff @(posedge CC_clk) begin
      if (accept) begin
         addr_q  <= mem_addr;
         we_q    <= mem_we;
         wdata_q <= mem_wdata;
      end
   end

   always_ff @(posedge CC_clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         mem_busy   <= 1'b0;
         mem_rvalid <= 1'b0;
         mem_wack   <= 1'b0;
         mem_rdata  <= '0;
         mem_beat   <= '0;
      end else begin
         mem_rvalid <= 1'b0;
         mem_wack   <= 1'b0;

         case (state_q)
            ST_WAIT: begin
               cnt_q <= cnt_d;
               if (cnt_d == '0) begin
                  state_q <= we_q ? ST_WRITE : ST_BURST;
                  idx_q   <= '0;
               end
            end
            ST_BURST: begin
               if (!burst_done) begin
                  mem_rvalid <= 1'b1;
                  mem_rdata  <= rd_data;
                  mem_beat   <= idx_q[BEAT_W-1:0];
                  idx_q      <= idx_q + IDX_W'(1);
               end
            end
            // The array commits on this same edge, so the ack and the
            // write land together.
            ST_WRITE: mem_wack <= 1'b1;
            default: ;
         endcase

         if (accept) begin
            state_q  <= ST_WAIT;
            cnt_q    <= CNT_W'(LATENCY);
            mem_busy <= 1'b1;
         end else if ((state_q == ST_WRITE) || burst_done) begin
            state_q  <= ST_IDLE;
            mem_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

   localparam int LAT = 3;
   localparam int LW  = 4;

   logic       CC_clk = 1'b0;
   logic       rst;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_busy;
   logic       mem_rvalid;
   logic [7:0] mem_rdata;
   logic [1:0] mem_beat;
   logic       mem_wack;

   main_memory_responder #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .LINE_WORDS (LW),
      .LATENCY    (LAT)
   ) dut (
      .CC_clk     (CC_clk),
      .rst        (rst),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_busy   (mem_busy),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .mem_beat   (mem_beat),
      .mem_wack   (mem_wack)
   );

   always #5 CC_clk = ~CC_clk;

   int cyc = 0;
   always @(posedge CC_clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard: expected read beats and expected write-ack cycles.
   typedef struct {
      logic [7:0] d;
      logic [1:0] b;
      int         c;
   } beat_t;

   beat_t rq[$];
   int    wq[$];
   beat_t mon_e;
   int    mon_w;

   always @(negedge CC_clk) begin
      if (!rst) begin
         if (mem_rvalid || mem_wack) chk("rvalid_wack_exclusive", 32'(mem_rvalid & mem_wack), 0);
         if (mem_rvalid) begin
            chk("rvalid_expected", 32'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
               mon_e = rq.pop_front();
               chk("rdata", 32'(mem_rdata), 32'(mon_e.d));
               chk("beat", 32'(mem_beat), 32'(mon_e.b));
               chk("beat_cycle", cyc, mon_e.c);
            end
         end
         if (mem_wack) begin
            chk("wack_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
               mon_w = wq.pop_front();
               chk("wack_cycle", cyc, mon_w);
            end
         end
      end
   end

   // Drive one request for a single sampling edge; n = edge number.
   task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] wd, output int n);
      @(negedge CC_clk);
      mem_req   = 1'b1;
      mem_we    = we;
      mem_addr  = a;
      mem_wdata = wd;
      @(posedge CC_clk);
      #1;
      n       = cyc;
      mem_req = 1'b0;
      chk("busy_after_req", 32'(mem_busy), 1);
   endtask

   // Beat k of exp is exp[8k +: 8]; only the first nb beats are expected.
   task automatic push_line(input int n, input logic [31:0] exp, input int nb);
      beat_t e;
      for (int k = 0; k < nb; k++) begin
         e.d = exp[8*k +: 8];
         e.b = 2'(k);
         e.c = n + LAT + 1 + k;
         rq.push_back(e);
      end
   endtask

   task automatic wait_idle(output int t);
      t = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CC_clk);
         if (!mem_busy) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk("idle_timeout", 32'(mem_busy), 0);
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n, t;

      vecs[0] = '{1'b0, 8'h05, 8'h00, 32'h07060504};
      vecs[1] = '{1'b1, 8'h01, 8'h0F, 32'h00000000};
      vecs[2] = '{1'b0, 8'h00, 8'h00, 32'h03020F00};
      vecs[3] = '{1'b0, 8'hFE, 8'h00, 32'hFFFEFDFC};
      vecs[4] = '{1'b1, 8'h42, 8'hA5, 32'h00000000};
      vecs[5] = '{1'b0, 8'h41, 8'h00, 32'h43A54140};
      vecs[6] = '{1'b1, 8'hFF, 8'h3C, 32'h00000000};
      vecs[7] = '{1'b0, 8'hFC, 8'h00, 32'h3CFEFDFC};

      rst       = 1'b1;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      repeat (2) @(negedge CC_clk);
      chk("reset_busy",   32'(mem_busy),   0);
      chk("reset_rvalid", 32'(mem_rvalid), 0);
      chk("reset_wack",   32'(mem_wack),   0);
      chk("reset_rdata",  32'(mem_rdata),  0);
      chk("reset_beat",   32'(mem_beat),   0);
      rst = 1'b0;

      // Table-driven transactions.
      for (int i = 0; i < 8; i++) begin
         issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, n);
         if (vecs[i].we) wq.push_back(n + LAT + 1);
         else            push_line(n, vecs[i].exp, LW);
         wait_idle(t);
         if (vecs[i].we) begin
            chk("write_idle_cycle", t, n + LAT + 1);
         end else begin
            chk("read_idle_cycle", t, n + LAT + LW + 1);
            chk("rq_drained", rq.size(), 0);
            chk("rdata_hold", 32'(mem_rdata), 32'(vecs[i].exp[31:24]));
         end
      end

      // Write request pulsed mid-burst must be dropped.
      issue(1'b0, 8'h10, 8'h00, n);
      push_line(n, 32'h13121110, LW);
      repeat (6) @(negedge CC_clk);
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 8'h11;
      mem_wdata = 8'hEE;
      @(negedge CC_clk);
      mem_req = 1'b0;
      wait_idle(t);
      chk("ignored_req_idle_cycle", t, n + LAT + LW + 1);
      issue(1'b0, 8'h10, 8'h00, n);
      push_line(n, 32'h13121110, LW);
      wait_idle(t);
      chk("ignored_req_rq_drained", rq.size(), 0);

      // Reset during beat 2 aborts the burst and restores the memory.
      issue(1'b0, 8'h20, 8'h00, n);
      push_line(n, 32'h00222120, 3);
      repeat (7) @(negedge CC_clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_rvalid", 32'(mem_rvalid), 0);
      chk("abort_busy",   32'(mem_busy),   0);
      chk("abort_rdata",  32'(mem_rdata),  0);
      chk("abort_rq_drained", rq.size(), 0);
      @(negedge CC_clk);
      rst = 1'b0;
      issue(1'b0, 8'h00, 8'h00, n);
      push_line(n, 32'h03020100, LW);
      wait_idle(t);
      chk("post_reset_idle_cycle", t, n + LAT + LW + 1);

      // Two writes to 0x00 with mem_req held: second taken on the first
      // write's completion edge.
      @(negedge CC_clk);
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 8'h00;
      mem_wdata = 8'h05;
      @(posedge CC_clk);
      #1;
      n = cyc;
      wq.push_back(n + LAT + 1);
      wq.push_back(n + 2 * (LAT + 1));
      @(negedge CC_clk);
      mem_wdata = 8'h15;
      repeat (LAT + 1) @(posedge CC_clk);
      #1;
      mem_req = 1'b0;
      chk("b2b_second_accepted", 32'(mem_busy), 1);
      wait_idle(t);
      chk("b2b_idle_cycle", t, n + 2 * (LAT + 1));
      issue(1'b0, 8'h00, 8'h00, n);
      push_line(n, 32'h03020115, LW);
      wait_idle(t);

      repeat (5) @(negedge CC_clk);
      chk("final_rq_empty", rq.size(), 0);
      chk("final_wq_empty", wq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
